// File: rtl/logic_analyzer_pkg.sv
// rtl/logic_analyzer_pkg.sv - shared constants, FSM states and frame helpers for transfer
package logic_analyzer_pkg;

   localparam int          NUM_CH      = 4;
   localparam int          WORD_W      = 32;
   localparam logic [3:0]  HDR_MAGIC   = 4'hA;
   localparam int          FRAME_BYTES = 5;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } state_t;

   // Lowest offset from ptr wins, so scan offsets from the far end downwards.
   function automatic logic [1:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [1:0] ptr);
      logic [1:0] pick;
      logic [1:0] k;
      pick = ptr;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         k = ptr + 2'(i);
         if (req[k]) pick = k;
      end
      return pick;
   endfunction

   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [1:0] ch,
                                             input logic [WORD_W-1:0] word);
      logic [7:0] b;
      case (idx)
         3'd0:    b = {HDR_MAGIC, 2'b00, ch};
         3'd1:    b = word[31:24];
         3'd2:    b = word[23:16];
         3'd3:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/transfer_uart_tx.sv
// rtl/transfer_uart_tx.sv - 8N1 LSB-first serialiser; accepts a new byte on the done cycle
module uart_tx #(
   parameter int BAUD_PRESCALER = 5
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic [7:0] i_byte,
   output logic       o_tx,
   output logic       o_done
);

   localparam int             CW      = (BAUD_PRESCALER > 1) ? $clog2(BAUD_PRESCALER) : 1;
   localparam logic [CW-1:0]  PRE_MAX = CW'(BAUD_PRESCALER - 1);

   logic          busy_q, busy_d;
   logic [9:0]    shift_q, shift_d;
   logic [3:0]    bit_q, bit_d;
   logic [CW-1:0] pre_q, pre_d;
   logic          bit_end;

   assign bit_end = (pre_q == PRE_MAX);
   assign o_done  = busy_q && bit_end && (bit_q == 4'd9);
   assign o_tx    = busy_q ? shift_q[0] : 1'b1;

   always_comb begin
      busy_d  = busy_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      pre_d   = pre_q;
      // Loading on the done cycle keeps consecutive bytes gap-free.
      if (i_start && (!busy_q || o_done)) begin
         busy_d  = 1'b1;
         shift_d = {1'b1, i_byte, 1'b0};
         bit_d   = 4'd0;
         pre_d   = '0;
      end else if (busy_q) begin
         if (bit_end) begin
            pre_d = '0;
            if (bit_q == 4'd9) begin
               busy_d = 1'b0;
            end else begin
               shift_d = {1'b1, shift_q[9:1]};
               bit_d   = bit_q + 4'd1;
            end
         end else begin
            pre_d = pre_q + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_q  <= 1'b0;
         shift_q <= 10'h3FF;
         bit_q   <= 4'd0;
         pre_q   <= '0;
      end else begin
         busy_q  <= busy_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         pre_q   <= pre_d;
      end
   end

endmodule

// File: rtl/transfer.sv
// rtl/transfer.sv - round-robin drain of four capture channels into 5-byte UART frames
module transfer
   import logic_analyzer_pkg::*;
#(
   parameter int BAUD_PRESCALER = 5
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_CH*WORD_W-1:0] data_in,
   input  logic [NUM_CH-1:0]        available,
   output logic [NUM_CH-1:0]        read,
   output logic [WORD_W-1:0]        o_word,
   output logic                     o_busy,
   output logic                     o_tx
);

   state_t            state_q, state_d;
   logic [1:0]        rr_q, rr_d;
   logic [1:0]        ch_q, ch_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [NUM_CH-1:0] read_q, read_d;
   logic              busy_q, busy_d;
   logic [2:0]        idx_q, idx_d;
   logic [1:0]        grant_ch;
   logic              tx_start;
   logic [7:0]        tx_byte;
   logic              tx_done;

   assign grant_ch = rr_pick(available, rr_q);
   assign read     = read_q;
   assign o_word   = word_q;
   assign o_busy   = busy_q;

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      ch_d     = ch_q;
      word_d   = word_q;
      read_d   = '0;
      busy_d   = busy_q;
      idx_d    = idx_q;
      tx_start = 1'b0;
      tx_byte  = 8'h00;
      case (state_q)
         IDLE: begin
            if (|available) begin
               ch_d    = grant_ch;
               word_d  = data_in[WORD_W*int'(grant_ch) +: WORD_W];
               read_d  = NUM_CH'(1) << grant_ch;
               rr_d    = grant_ch + 2'd1;
               busy_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            tx_start = 1'b1;
            tx_byte  = frame_byte(3'd0, ch_q, word_q);
            idx_d    = 3'd0;
            state_d  = SEND;
         end
         SEND: begin
            if (tx_done) begin
               if (idx_q == 3'(FRAME_BYTES - 1)) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  tx_start = 1'b1;
                  tx_byte  = frame_byte(idx_q + 3'd1, ch_q, word_q);
                  idx_d    = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         rr_q    <= 2'd0;
         ch_q    <= 2'd0;
         word_q  <= '0;
         read_q  <= '0;
         busy_q  <= 1'b0;
         idx_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         ch_q    <= ch_d;
         word_q  <= word_d;
         read_q  <= read_d;
         busy_q  <= busy_d;
         idx_q   <= idx_d;
      end
   end

   uart_tx #(.BAUD_PRESCALER(BAUD_PRESCALER)) u_uart_tx (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (tx_start),
      .i_byte  (tx_byte),
      .o_tx    (o_tx),
      .o_done  (tx_done)
   );

endmodule

// File: tb/tb_transfer.sv
// tb/tb_transfer.sv - self-checking bench for transfer with a line-level UART decoder
module tb_transfer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] data0, data1;
   logic [3:0]   avail0, avail1;
   logic [3:0]   read0, read1;
   logic [31:0]  word0, word1;
   logic         busy0, busy1, tx0, tx1;

   int checks = 0;
   int failures = 0;
   int pulses = 0;
   int multi = 0;
   int grants = 0;
   int ptr = 0;

   always #5 clk = ~clk;

   transfer #(.BAUD_PRESCALER(5)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .data_in(data0), .available(avail0),
      .read(read0), .o_word(word0), .o_busy(busy0), .o_tx(tx0)
   );

   transfer #(.BAUD_PRESCALER(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .data_in(data1), .available(avail1),
      .read(read1), .o_word(word1), .o_busy(busy1), .o_tx(tx1)
   );

   always @(negedge clk) begin
      if (read0 !== 4'b0000) pulses++;
      if ($countones(read0) > 1) multi++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] mask, input int p);
      for (int i = 0; i < 4; i++)
         if (mask[(p + i) % 4]) return (p + i) % 4;
      return -1;
   endfunction

   function automatic logic [39:0] exp_frame(input int ch, input logic [31:0] w);
      logic [1:0] c;
      c = 2'(ch);
      return {4'hA, 2'b00, c, w};
   endfunction

   task automatic wait_read(input int sel, output logic [3:0] r, output bit ok);
      int w;
      w = 0;
      ok = 1;
      do begin
         @(negedge clk);
         r = sel ? read1 : read0;
         w++;
      end while (r === 4'b0000 && w < 3000);
      if (r === 4'b0000) ok = 0;
   endtask

   task automatic recv_frame(input int sel, input int p, output logic [39:0] fr, output bit ok);
      logic b, v;
      logic [7:0] byt;
      bit first;
      int w;
      ok = 1;
      fr = '0;
      byt = '0;
      v = 1'b1;
      w = 0;
      b = sel ? tx1 : tx0;
      while (b !== 1'b0 && w < 3000) begin
         @(negedge clk);
         b = sel ? tx1 : tx0;
         w++;
      end
      if (b !== 1'b0) begin
         ok = 0;
         return;
      end
      first = 1;
      for (int by = 0; by < 5; by++) begin
         for (int bt = 0; bt < 10; bt++) begin
            for (int c = 0; c < p; c++) begin
               if (!first) @(negedge clk);
               first = 0;
               b = sel ? tx1 : tx0;
               if (c == 0) v = b;
               else if (b !== v) ok = 0;
            end
            if (bt == 0 && v !== 1'b0) ok = 0;
            if (bt == 9 && v !== 1'b1) ok = 0;
            if (bt >= 1 && bt <= 8) byt[bt-1] = v;
         end
         fr = {fr[31:0], byt};
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ptr = 0;
   endtask

   initial begin
      logic [3:0]  r;
      logic [39:0] fr;
      logic [31:0] w;
      bit          ok;
      int          bad, ch;
      time         t_prev;
      logic [3:0]  mask;

      rst_n = 1'b0;
      data0 = '0; data1 = '0; avail0 = '0; avail1 = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", 64'(tx0), 64'd1);
      check("rst_read", 64'(read0), 64'd0);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_word", 64'(word0), 64'd0);
      rst_n = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || read0 !== 4'b0 || busy0 !== 1'b0) bad++;
      end
      check("idle_quiet", 64'(bad), 64'd0);

      data0 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
      avail0 = 4'b0100;
      wait_read(0, r, ok);
      avail0 = 4'b0000;
      check("pulse_read", 64'(r), 64'h4);
      check("pulse_word", 64'(word0), 64'hBBBBBBBB);
      check("pulse_busy", 64'(busy0), 64'd1);
      grants++; ptr = 3;
      recv_frame(0, 5, fr, ok);
      check("pulse_bits", 64'(ok), 64'd1);
      check("pulse_frame", 64'(fr), 64'hA2BBBBBBBB);
      @(negedge clk);
      check("pulse_busy_end", 64'(busy0), 64'd0);
      repeat (10) @(negedge clk);
      check("pulse_count", 64'(pulses), 64'd1);

      avail0 = 4'b0100;
      t_prev = 0;
      for (int n = 0; n < 3; n++) begin
         wait_read(0, r, ok);
         check("held_read", 64'(r), 64'h4);
         if (n > 0) check("held_gap", 64'(($time - t_prev) / 10 >= 250), 64'd1);
         t_prev = $time;
         grants++;
         recv_frame(0, 5, fr, ok);
         check("held_frame", 64'(fr), 64'hA2BBBBBBBB);
      end
      avail0 = 4'b0000;
      repeat (5) @(negedge clk);
      check("held_pulses", 64'(pulses), 64'(grants));

      do_reset();
      avail0 = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_read(0, r, ok);
         ch = n % 4;
         check("rr_read", 64'(r), 64'(4'b1 << ch));
         grants++;
         recv_frame(0, 5, fr, ok);
         check("rr_frame", 64'(fr), 64'(exp_frame(ch, data0[32*ch +: 32])));
      end
      avail0 = 4'b0000;
      ptr = 1;

      data1 = {$urandom, $urandom, $urandom, $urandom};
      avail1 = 4'b1000;
      wait_read(1, r, ok);
      avail1 = 4'b0000;
      check("p1_read", 64'(r), 64'h8);
      w = data1[127:96];
      data1 = ~data1;
      recv_frame(1, 1, fr, ok);
      check("p1_bits", 64'(ok), 64'd1);
      check("p1_frame", 64'(fr), 64'(exp_frame(3, w)));

      repeat (5) @(negedge clk);
      avail0 = 4'b0001;
      wait_read(0, r, ok);
      avail0 = 4'b0000;
      grants++;
      repeat (2 * 50 + 13) @(negedge clk);
      check("abort_busy_before", 64'(busy0), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_tx", 64'(tx0), 64'd1);
      check("abort_busy", 64'(busy0), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ptr = 0;
      avail0 = 4'b0010;
      wait_read(0, r, ok);
      avail0 = 4'b0000;
      check("abort_new_read", 64'(r), 64'h2);
      grants++; ptr = 2;
      recv_frame(0, 5, fr, ok);
      check("abort_new_frame", 64'(fr), 64'(exp_frame(1, 32'hCCCCCCCC)));

      for (int n = 0; n < 8; n++) begin
         mask = 4'($urandom_range(1, 15));
         data0 = {$urandom, $urandom, $urandom, $urandom};
         avail0 = mask;
         ch = pick(mask, ptr);
         wait_read(0, r, ok);
         check("rand_read", 64'(r), 64'(4'b1 << ch));
         w = data0[32*ch +: 32];
         check("rand_word", 64'(word0), 64'(w));
         ptr = (ch + 1) % 4;
         grants++;
         data0 = {$urandom, $urandom, $urandom, $urandom};
         recv_frame(0, 5, fr, ok);
         check("rand_bits", 64'(ok), 64'd1);
         check("rand_frame", 64'(fr), 64'(exp_frame(ch, w)));
      end
      avail0 = 4'b0000;
      repeat (5) @(negedge clk);
      check("total_pulses", 64'(pulses), 64'(grants));
      check("onehot_read", 64'(multi), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
